// File: rtl/fifo_prog_if.sv
// Handshake/status bundle between a producer/consumer pair and fifo_prog.
// The master side drives requests and thresholds; the slave side is the FIFO.
interface fifo_prog_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
);
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [CNT_W-1:0]      af_thresh;
    logic [CNT_W-1:0]      ae_thresh;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CNT_W-1:0]      count;

    modport master (
        output wr_en, rd_en, data_in, af_thresh, ae_thresh,
        input  data_out, wr_ack, overflow, underflow, full, empty,
               almostfull, almostempty, count
    );

    modport slave (
        input  wr_en, rd_en, data_in, af_thresh, ae_thresh,
        output data_out, wr_ack, overflow, underflow, full, empty,
               almostfull, almostempty, count
    );
endinterface

// File: rtl/fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty levels and registered error pulses.
// Define FIFO_FWFT_EN for first-word fall-through reads; otherwise data_out is a registered read.
module fifo_prog #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input logic        clk,
    input logic        rst,
    fifo_prog_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  full_s, empty_s, wr_acc_s, rd_acc_s;
`ifndef FIFO_FWFT_EN
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
`endif

    // Acceptance decisions and next-state for pointers, occupancy and pulse flags.
    always_comb begin
        full_s      = (count_q == DEPTH_C);
        empty_s     = (count_q == CNT_ZERO);
        wr_acc_s    = bus.wr_en & ~full_s;
        rd_acc_s    = bus.rd_en & ~empty_s;
        wr_ptr_d    = wr_acc_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d    = rd_acc_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        wr_ack_d    = wr_acc_s;
        overflow_d  = bus.wr_en & full_s;
        underflow_d = bus.rd_en & empty_s;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
`ifndef FIFO_FWFT_EN
        // A rejected read leaves the last word on the output.
        dout_d = rd_acc_s ? mem_q[rd_ptr_q] : dout_q;
`endif
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`ifndef FIFO_FWFT_EN
            dout_q      <= {DATA_WIDTH{1'b0}};
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`ifndef FIFO_FWFT_EN
            dout_q      <= dout_d;
`endif
        end
    end

    // Storage array; deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign bus.full        = full_s;
    assign bus.empty       = empty_s;
    assign bus.almostfull  = (count_q >= bus.af_thresh);
    assign bus.almostempty = (count_q <= bus.ae_thresh);
    assign bus.count       = count_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
`ifdef FIFO_FWFT_EN
    assign bus.data_out    = empty_s ? {DATA_WIDTH{1'b0}} : mem_q[rd_ptr_q];
`else
    assign bus.data_out    = dout_q;
`endif
endmodule

// File: tb/tb_fifo_prog.sv
// Scoreboard bench for fifo_prog: stimulus pushes per-cycle expectations from a queue model,
// a monitor pops and compares them one time unit after each rising edge.
module tb_fifo_prog;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        int cnt;
        bit full;
        bit empty;
        bit af;
        bit ae;
        bit ack;
        bit ovf;
        bit udf;
        int dout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_prog_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();
    fifo_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [DW-1:0] mdl[$];
    logic [DW-1:0] mdl_dout = '0;
    exp_t          exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, expv);
        end
    endtask

    // Expected outputs after the coming edge, from the model's queue contents.
    function automatic exp_t expect_now(input bit ack, input bit ovf, input bit udf);
        exp_t e;
        int   sz = mdl.size();
        e.cnt   = sz;
        e.full  = (sz == DEPTH);
        e.empty = (sz == 0);
        e.af    = (sz >= int'(bus.af_thresh));
        e.ae    = (sz <= int'(bus.ae_thresh));
        e.ack   = ack;
        e.ovf   = ovf;
        e.udf   = udf;
`ifdef FIFO_FWFT_EN
        e.dout  = (sz > 0) ? int'(mdl[0]) : 0;
`else
        e.dout  = int'(mdl_dout);
`endif
        return e;
    endfunction

    task automatic check_rec(input exp_t e, input string tag);
        chk({tag, "_count"},     32'(bus.count),       32'(e.cnt));
        chk({tag, "_full"},      32'(bus.full),        32'(e.full));
        chk({tag, "_empty"},     32'(bus.empty),       32'(e.empty));
        chk({tag, "_almostfull"},  32'(bus.almostfull),  32'(e.af));
        chk({tag, "_almostempty"}, 32'(bus.almostempty), 32'(e.ae));
        chk({tag, "_wr_ack"},    32'(bus.wr_ack),      32'(e.ack));
        chk({tag, "_overflow"},  32'(bus.overflow),    32'(e.ovf));
        chk({tag, "_underflow"}, 32'(bus.underflow),   32'(e.udf));
        chk({tag, "_data_out"},  32'(bus.data_out),    32'(e.dout));
    endtask

    // One cycle of traffic; called at a falling edge, returns at the next one.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
        bit wok, rok;
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.data_in = d;
        wok = w && (mdl.size() < DEPTH);
        rok = r && (mdl.size() > 0);
        if (rok) mdl_dout = mdl.pop_front();
        if (wok) mdl.push_back(d);
        exp_q.push_back(expect_now(wok, w && !wok, r && !rok));
        @(negedge clk);
    endtask

    task automatic reset_for(input int cycles);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        rst       = 1'b1;
        mdl.delete();
        mdl_dout  = '0;
        #1;
        check_rec(expect_now(1'b0, 1'b0, 1'b0), "async_rst");
        for (int i = 0; i < cycles; i++) begin
            exp_q.push_back(expect_now(1'b0, 1'b0, 1'b0));
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_rec(e, "cyc");
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int wp;
        int rp;
        bus.wr_en     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.data_in   = '0;
        bus.af_thresh = CW'(7);
        bus.ae_thresh = CW'(1);
        @(negedge clk);
        reset_for(2);

        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(i));
        step(1'b1, 1'b0, 16'h0009);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 16'h0000);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'($urandom_range(0, 65535)));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DW'($urandom_range(0, 65535)));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0000);
        step(1'b1, 1'b1, 16'h1234);
        step(1'b0, 1'b1, 16'h0000);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom_range(0, 65535)));
        reset_for(2);
        step(1'b1, 1'b0, 16'h5A5A);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);

        step(1'b1, 1'b0, 16'hABCD);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);

        // Random traffic with phase-varying bias, moving thresholds and rare resets.
        for (int i = 0; i < 400; i++) begin
            case (i / 100)
                0:       begin wp = 75; rp = 30; end
                1:       begin wp = 30; rp = 75; end
                2:       begin wp = 90; rp = 85; end
                default: begin wp = 50; rp = 50; end
            endcase
            if ($urandom_range(0, 15) == 0) begin
                bus.af_thresh = CW'($urandom_range(0, DEPTH));
                bus.ae_thresh = CW'($urandom_range(0, DEPTH));
            end
            if ($urandom_range(0, 199) == 0) reset_for(1);
            step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                 DW'($urandom_range(0, 65535)));
        end

        step(1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_prog.md
# fifo_prog

Parametrised synchronous FIFO with run-time programmable almost-full/almost-empty thresholds, an occupancy count and registered handshake/error flags. It is the next generation of the team's fixed-size FIFO. It sits between a single producer and a single consumer in one clock domain and is a drop-in buffer for datapath stages. An optional first-word fall-through (FWFT) read mode is selectable at compile time.

## Interface
Parameters:
- DATA_WIDTH, 16, width of data_in/data_out.
- FIFO_DEPTH, 8, number of entries; power of two, ≥ 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of count and threshold ports (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- data_in  in  DATA_WIDTH  write data.
- af_thresh  in  CNT_W  almost-full level.
- ae_thresh  in  CNT_W  almost-empty level.
- data_out  out  DATA_WIDTH  read data.
- wr_ack  out  1  registered: previous cycle's write accepted.
- overflow  out  1  registered: previous cycle's write rejected (full).
- underflow  out  1  registered: previous cycle's read rejected (empty).
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  count == 0.
- almostfull  out  1  count ≥ af_thresh.
- almostempty  out  1  count ≤ ae_thresh.
- count  out  CNT_W  current occupancy, 0..FIFO_DEPTH.

## Operation
- Storage: FIFO_DEPTH × DATA_WIDTH array; wr_ptr and rd_ptr are $clog2(FIFO_DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write accepted iff wr_en && !full. It stores data_in at wr_ptr and increments wr_ptr.
- Read accepted iff rd_en && !empty. It increments rd_ptr.
- Simultaneous wr_en && rd_en:
  - Neither full nor empty: both accepted; count unchanged.
  - Full: read only; write rejected, overflow flagged.
  - Empty: write only; read rejected, underflow flagged.
- count: +1 on write-only, −1 on read-only, unchanged otherwise. It never exceeds FIFO_DEPTH and never goes below 0.
- Status flags full, empty, almostfull and almostempty are combinational from count and the threshold ports. Threshold ports may change at any time and take effect the same cycle.
- Error flags are single-cycle pulses; they are not sticky.
- Reset (any time, including mid-transfer):
  - wr_ptr, rd_ptr and count = 0; data_out = 0.
  - wr_ack, overflow and underflow = 0.
  - empty = 1, full = 0, almostempty = 1 (count 0 ≤ any threshold).
  - almostfull = 1 only if af_thresh == 0.
  - Memory contents are not cleared.

## Timing
- Write-to-visible: a word written at edge N is readable from edge N+1 (count and empty update at N).
- Standard mode: data_out is registered. It loads mem[rd_ptr] at the edge of an accepted read and holds its value otherwise, including on a rejected read.
- wr_ack, overflow and underflow are valid the cycle after the request edge, for one cycle.
- Back-to-back reads and writes are supported every cycle; throughput is 1 word/cycle each way.

## Configuration
- FIFO_FWFT_EN defined: first-word fall-through.
  - data_out = mem[rd_ptr] combinationally whenever !empty; it equals 0 when empty.
  - rd_en acknowledges (pops) the word currently shown.
  - A word written at edge N appears on data_out after edge N, with zero read latency.
- FIFO_FWFT_EN undefined: standard registered read as described under Timing. data_out follows rd_en by one cycle.

## Test plan
- Reset, then af_thresh=7 and ae_thresh=1 → empty=1, almostempty=1, full=0, almostfull=0, count=0, data_out=0.
- Write 0x0001..0x0008 on consecutive cycles (DEPTH=8) → wr_ack=1 each following cycle; almostfull rises when count=7; full=1 when count=8. A 9th write → overflow=1 for one cycle, count stays 8.
- Read 8 words (standard mode) → data_out = 0x0001..0x0008 in order, each one cycle after rd_en. A 9th read → underflow=1, data_out holds 0x0008.
- With count=4, assert wr_en and rd_en together for 20 cycles → count stays 4 and data order is preserved across pointer wrap. With count=0 and both asserted → write only, underflow=1, count=1.
- Assert rst with count=5 mid-stream, deasserting after 2 cycles → all outputs return to reset values immediately (asynchronously); the next write/read pair returns the new data.
- With FIFO_FWFT_EN defined, write 0xABCD into an empty FIFO → data_out=0xABCD the cycle after the write with no rd_en; after rd_en, empty=1 and data_out=0.
